// File: rtl/id_issue.sv
// ---------------------------------------------------------------------------
// id_issue -- dual-issue decode/issue stage (IF/ID -> ID/EX).
//
// Takes an instruction pair from the IF/ID register and loads the ID/EX
// register one cycle later. It can issue both slots, issue slot 1 alone and
// ask fetch to re-present slot 2 as the next slot 1, or insert a bubble for
// one cycle when slot 1 in EX is a load whose result the pair needs.
//
// Flow-control contract with fetch (the only handshake here):
//   FREEZE=1       : IF/ID must hold its pair this cycle; ID/EX takes a bubble.
//   single_fetch=1 : only slot 1 was accepted; fetch re-presents slot 2 as
//                    slot 1 next cycle.
//   Both low       : the whole pair was accepted (or squashed by FLUSH).
//   FREEZE and single_fetch are never high together, and both stay low
//   while RESET is asserted.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-low reset
//   Instr1_IN/2_IN    slot-1 / slot-2 instruction from IF/ID
//   CIA_IN            address of Instr1_IN
//   FLUSH             taken-branch squash of ID/EX (highest priority)
//   Instr1_EX/2_EX    ID/EX instruction registers
//   V1_EX/V2_EX       ID/EX slot-valid flags
//   CIA_EX            registered CIA_IN
//   single_fetch      combinational, slot 2 not issued
//   FREEZE            combinational, hold IF/ID
//   fsm_state         debug view of the FSM (0 = RUN, 1 = LU_STALL)
//   split_cnt         (ID_ISSUE_STATS_EN only) split-issue counter
//   stall_cnt         (ID_ISSUE_STATS_EN only) load-use stall counter
//
// Build option: define ID_ISSUE_STATS_EN to add split_cnt / stall_cnt.
// ---------------------------------------------------------------------------
module id_issue (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr2_IN,
  input  logic [31:0] CIA_IN,
  input  logic        FLUSH,
  output logic [31:0] Instr1_EX,
  output logic [31:0] Instr2_EX,
  output logic        V1_EX,
  output logic        V2_EX,
  output logic [31:0] CIA_EX,
  output logic        single_fetch,
  output logic        FREEZE,
  output logic        fsm_state
`ifdef ID_ISSUE_STATS_EN
  ,
  output logic [15:0] split_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Destination register; 0 means "no destination" (r0 is never written).
  function automatic logic [4:0] dest_of(input logic [5:0] op,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd);
    logic [4:0] d;
    d = 5'd0;
    if (op == 6'h00)
      d = rd;
    else if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h25))
      d = rt;
    return d;
  endfunction

  // True when the instruction reads register r (r0 never creates a hazard).
  function automatic logic reads(input logic [5:0] op,
                                 input logic [4:0] rs,
                                 input logic [4:0] rt,
                                 input logic [4:0] r);
    logic rt_src;
    rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
             (op >= 6'h28 && op <= 6'h2B);
    return (r != 5'd0) && ((rs == r) || (rt_src && (rt == r)));
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op >= 6'h20) && (op <= 6'h2B);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op >= 6'h20) && (op <= 6'h25);
  endfunction

  logic [4:0] d1;
  logic [4:0] ex_rt;
  logic       pair_conflict;
  logic       load_use;
  logic       freeze;
  logic       split;

  assign d1 = dest_of(Instr1_IN[31:26], Instr1_IN[20:16], Instr1_IN[15:11]);

  assign pair_conflict =
      ((d1 != 5'd0) && reads(Instr2_IN[31:26], Instr2_IN[25:21], Instr2_IN[20:16], d1)) ||
      (is_mem(Instr1_IN[31:26]) && is_mem(Instr2_IN[31:26]));

  assign ex_rt = Instr1_EX[20:16];

  assign load_use = V1_EX && is_load(Instr1_EX[31:26]) && (ex_rt != 5'd0) &&
                    (reads(Instr1_IN[31:26], Instr1_IN[25:21], Instr1_IN[20:16], ex_rt) ||
                     reads(Instr2_IN[31:26], Instr2_IN[25:21], Instr2_IN[20:16], ex_rt));

  // Next-state / issue decision. FLUSH wins; a held pair (LU_STALL) is
  // issued without repeating the load-use check.
  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    split   = 1'b0;
    if (FLUSH) begin
      state_d = RUN;
    end else if ((state_q == RUN) && load_use) begin
      freeze  = 1'b1;
      state_d = LU_STALL;
    end else begin
      state_d = RUN;
      split   = pair_conflict;
    end
  end

  // Gate with RESET so fetch sees no stall/split request during reset.
  assign FREEZE       = RESET & freeze;
  assign single_fetch = RESET & split;
  assign fsm_state    = (state_q == LU_STALL);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr1_EX <= 32'd0;
      Instr2_EX <= 32'd0;
      CIA_EX    <= 32'd0;
      V1_EX     <= 1'b0;
      V2_EX     <= 1'b0;
    end else begin
      if (!freeze) begin
        CIA_EX <= CIA_IN;
      end
      if (FLUSH || freeze) begin
        Instr1_EX <= 32'd0;
        Instr2_EX <= 32'd0;
        V1_EX     <= 1'b0;
        V2_EX     <= 1'b0;
      end else begin
        Instr1_EX <= Instr1_IN;
        Instr2_EX <= split ? 32'd0 : Instr2_IN;
        V1_EX     <= 1'b1;
        V2_EX     <= ~split;
      end
    end
  end

`ifdef ID_ISSUE_STATS_EN
  // Free-running counters; they wrap naturally at 16 bits.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      split_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (split) begin
        split_cnt <= split_cnt + 16'd1;
      end
      if (freeze) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_issue.sv
// ---------------------------------------------------------------------------
// tb_id_issue -- self-checking bench for id_issue.
//
// A behavioural model tracks what ID/EX must hold and what FREEZE /
// single_fetch must be each cycle, derived from the instruction-pair rules;
// issued instructions go through an in-order expected queue. Directed cases
// with literal expectations come first, then randomized traffic from a
// fetch driver that honours FREEZE and single_fetch.
// ---------------------------------------------------------------------------
module tb_id_issue;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr1_IN = 32'd0;
  logic [31:0] Instr2_IN = 32'd0;
  logic [31:0] CIA_IN = 32'd0;
  logic        FLUSH = 1'b0;
  logic [31:0] Instr1_EX, Instr2_EX, CIA_EX;
  logic        V1_EX, V2_EX, single_fetch, FREEZE, fsm_state;
`ifdef ID_ISSUE_STATS_EN
  logic [15:0] split_cnt, stall_cnt;
`endif

  always #5 CLK = ~CLK;

  id_issue dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Instr1_IN    (Instr1_IN),
    .Instr2_IN    (Instr2_IN),
    .CIA_IN       (CIA_IN),
    .FLUSH        (FLUSH),
    .Instr1_EX    (Instr1_EX),
    .Instr2_EX    (Instr2_EX),
    .V1_EX        (V1_EX),
    .V2_EX        (V2_EX),
    .CIA_EX       (CIA_EX),
    .single_fetch (single_fetch),
    .FREEZE       (FREEZE),
    .fsm_state    (fsm_state)
`ifdef ID_ISSUE_STATS_EN
    ,
    .split_cnt    (split_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction rules ----------------
  function automatic logic [4:0] tb_dest(input logic [31:0] w);
    int op;
    op = int'(w[31:26]);
    if (op == 0) return w[15:11];
    if (op inside {[8:15], [32:37]}) return w[20:16];
    return 5'd0;
  endfunction

  function automatic bit tb_reads(input logic [31:0] w, input logic [4:0] r);
    int op;
    op = int'(w[31:26]);
    if (r == 5'd0) return 1'b0;
    if (w[25:21] == r) return 1'b1;
    if ((op inside {0, 4, 5, [40:43]}) && (w[20:16] == r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit tb_mem(input logic [31:0] w);
    return int'(w[31:26]) inside {[32:43]};
  endfunction

  function automatic bit tb_load(input logic [31:0] w);
    return int'(w[31:26]) inside {[32:37]};
  endfunction

  function automatic bit tb_conflict(input logic [31:0] a, input logic [31:0] b);
    logic [4:0] d;
    d = tb_dest(a);
    return ((d != 5'd0) && tb_reads(b, d)) || (tb_mem(a) && tb_mem(b));
  endfunction

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];           // issued instructions in program order
  bit          m_v1, m_v2, m_held;
  logic [31:0] m_cia, m_last_i1;
  logic [15:0] m_split, m_stall;

  task automatic pop_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=%h required=<nothing issued> t=%0t", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  initial begin : compare
    bit          lu, e_freeze, e_sf, conf;
    bit          n_v1, n_v2, n_held, push1, push2;
    logic [31:0] n_cia, n_last, p1, p2;
    logic [15:0] n_split, n_stall;
    m_v1 = 0; m_v2 = 0; m_held = 0; m_cia = 0; m_last_i1 = 0; m_split = 0; m_stall = 0;
    forever begin
      @(negedge CLK);
      #1;
      if (!RESET) begin
        m_v1 = 0; m_v2 = 0; m_held = 0; m_cia = 0; m_last_i1 = 0;
        m_split = 0; m_stall = 0;
        exp_q.delete();
        check("rst_i1", Instr1_EX, 32'd0);
        check("rst_i2", Instr2_EX, 32'd0);
      end
      check("v1", V1_EX, m_v1);
      check("v2", V2_EX, m_v2);
      check("cia", CIA_EX, m_cia);
      check("state", fsm_state, m_held);
      if (m_v1) begin
        pop_check("i1", Instr1_EX);
        if (m_v2) pop_check("i2", Instr2_EX);
        else check("i2_zero", Instr2_EX, 32'd0);
      end
`ifdef ID_ISSUE_STATS_EN
      check("split_cnt", split_cnt, m_split);
      check("stall_cnt", stall_cnt, m_stall);
`endif
      // What the pair currently in IF/ID must produce.
      lu = m_v1 && tb_load(m_last_i1) && (m_last_i1[20:16] != 5'd0) &&
           (tb_reads(Instr1_IN, m_last_i1[20:16]) || tb_reads(Instr2_IN, m_last_i1[20:16]));
      conf     = tb_conflict(Instr1_IN, Instr2_IN);
      e_freeze = RESET && !FLUSH && !m_held && lu;
      e_sf     = RESET && !FLUSH && !e_freeze && conf;
      check("freeze", FREEZE, e_freeze);
      check("single_fetch", single_fetch, e_sf);

      n_split = m_split; n_stall = m_stall; n_last = m_last_i1;
      push1 = 0; push2 = 0; p1 = Instr1_IN; p2 = Instr2_IN;
      if (FLUSH) begin
        n_v1 = 0; n_v2 = 0; n_held = 0; n_cia = CIA_IN;
      end else if (e_freeze) begin
        n_v1 = 0; n_v2 = 0; n_held = 1; n_cia = m_cia; n_stall = m_stall + 16'd1;
      end else begin
        n_v1 = 1; n_v2 = !conf; n_held = 0; n_cia = CIA_IN; n_last = Instr1_IN;
        push1 = 1; push2 = !conf;
        if (conf) n_split = m_split + 16'd1;
      end

      @(posedge CLK);
      if (RESET) begin
        m_v1 = n_v1; m_v2 = n_v2; m_held = n_held; m_cia = n_cia; m_last_i1 = n_last;
        m_split = n_split; m_stall = n_stall;
        if (push1) exp_q.push_back(p1);
        if (push2) exp_q.push_back(p2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit drv_f, drv_s;

  // Advance one cycle; remembers FREEZE / single_fetch of the cycle left.
  task automatic tick();
    @(negedge CLK);
    #3;
    drv_f = FREEZE;
    drv_s = single_fetch;
    @(posedge CLK);
    #2;
  endtask

  task automatic set_pair(input logic [31:0] a, input logic [31:0] b);
    Instr1_IN = a;
    Instr2_IN = b;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [0:7];
    logic [5:0] op;
    ops = '{6'h00, 6'h00, 6'h08, 6'h04, 6'h23, 6'h2B, 6'h20, 6'h02};
    if ($urandom_range(0, 15) == 0) return 32'd0;
    op = ops[$urandom_range(0, 7)];
    return {op, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            5'($urandom_range(0, 4)), 11'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    RESET = 0;
    tick();
    tick();
    check("lit_rst_v1", V1_EX, 1'b0);
    check("lit_rst_cia", CIA_EX, 32'd0);
    // Conflicting pair while in reset: no split request may escape.
    set_pair(32'h00221820, 32'h00642820);
    #1;
    check("lit_rst_sf", single_fetch, 1'b0);
    check("lit_rst_frz", FREEZE, 1'b0);
    tick();
    RESET = 1;

    // add r3 ; add r5,r3,r4 -> split
    #1;
    check("lit_raw_sf", single_fetch, 1'b1);
    tick();
    check("lit_raw_v1", V1_EX, 1'b1);
    check("lit_raw_v2", V2_EX, 1'b0);
    check("lit_raw_i1", Instr1_EX, 32'h00221820);

    // add r3 ; add r4,r6,r7 -> pair
    set_pair(32'h00221820, 32'h00C72020);
    CIA_IN = 32'h0000_0100;
    #1;
    check("lit_pair_sf", single_fetch, 1'b0);
    tick();
    check("lit_pair_v1", V1_EX, 1'b1);
    check("lit_pair_v2", V2_EX, 1'b1);
    check("lit_pair_cia", CIA_EX, 32'h0000_0100);

    // lw r3 then a reader of r3 -> one freeze, bubble, then issue
    set_pair(32'h8C030000, 32'd0);
    tick();
    set_pair(32'h00631020, 32'd0);
    #1;
    check("lit_lu_frz", FREEZE, 1'b1);
    check("lit_lu_sf", single_fetch, 1'b0);
    tick();
    check("lit_lu_bubble", V1_EX, 1'b0);
    check("lit_lu_state", fsm_state, 1'b1);
    check("lit_lu_frz2", FREEZE, 1'b0);
    tick();
    check("lit_lu_issue", Instr1_EX, 32'h00631020);
    check("lit_lu_v1", V1_EX, 1'b1);

    // FLUSH together with a load-use hazard
    set_pair(32'h8C030000, 32'd0);
    tick();
    set_pair(32'h00631020, 32'd0);
    FLUSH = 1;
    #1;
    check("lit_fl_frz", FREEZE, 1'b0);
    tick();
    FLUSH = 0;
    check("lit_fl_v1", V1_EX, 1'b0);
    check("lit_fl_v2", V2_EX, 1'b0);
    check("lit_fl_state", fsm_state, 1'b0);
    set_pair(32'd0, 32'd0);
    tick();

    // both memory ops -> split; counters start from a fresh reset
    RESET = 0;
    tick();
    RESET = 1;
    set_pair(32'h8C030000, 32'hAC040004);
    #1;
    check("lit_mem_sf", single_fetch, 1'b1);
    tick();
    check("lit_mem_v2", V2_EX, 1'b0);
`ifdef ID_ISSUE_STATS_EN
    check("lit_split_1", split_cnt, 16'd1);
    repeat (65534) tick();
    check("lit_split_ffff", split_cnt, 16'hFFFF);
    tick();
    check("lit_split_wrap", split_cnt, 16'h0000);
`endif

    // reset in the middle of a load-use stall
    set_pair(32'h8C030000, 32'd0);
    tick();
    set_pair(32'h00631020, 32'd0);
    tick();
    check("lit_mid_state", fsm_state, 1'b1);
    RESET = 0;
    #1;
    check("lit_mid_state0", fsm_state, 1'b0);
    check("lit_mid_v1", V1_EX, 1'b0);
    check("lit_mid_i1", Instr1_EX, 32'd0);
    check("lit_mid_cia", CIA_EX, 32'd0);
    tick();
    RESET = 1;
    #1;
    check("lit_mid_frz", FREEZE, 1'b0);
    tick();
    check("lit_mid_issue", V1_EX, 1'b1);

    // randomized fetch traffic
    drv_f = 0;
    drv_s = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drv_f) begin
        // IF/ID holds its pair
      end else if (drv_s) begin
        set_pair(Instr2_IN, rand_instr());
        CIA_IN = CIA_IN + 32'd4;
      end else begin
        set_pair(rand_instr(), rand_instr());
        CIA_IN = CIA_IN + 32'd8;
      end
      FLUSH = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        RESET = 0;
        tick();
        RESET = 1;
        drv_f = 0;
        drv_s = 0;
      end else begin
        tick();
      end
    end
    FLUSH = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_issue.md
ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 SHALL have: CLK  input  1  rising-edge clock.
REQ-002 SHALL have: RESET  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: Instr1_IN  input  32  slot-1 instruction from the IF/ID register.
REQ-004 SHALL have: Instr2_IN  input  32  slot-2 instruction from the IF/ID register.
REQ-005 SHALL have: CIA_IN  input  32  address of Instr1_IN.
REQ-006 SHALL have: FLUSH  input  1  taken-branch squash of the ID/EX register.
REQ-007 SHALL have: Instr1_EX, Instr2_EX  output  32 each  ID/EX instruction registers.
REQ-008 SHALL have: V1_EX, V2_EX  output  1 each  slot-valid flags.
REQ-009 SHALL have: CIA_EX  output  32  registered CIA_IN.
REQ-010 SHALL have: single_fetch  output  1  combinational; slot 2 not issued, IF re-presents it as slot 1.
REQ-011 SHALL have: FREEZE  output  1  combinational; holds IF/ID this cycle.

Function
REQ-012 Decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
REQ-013 Dest: op=0 -> rd; op 0x08-0x0F or 0x20-0x25 -> rt; otherwise none. Dest register 0 SHALL count as none.
REQ-014 rt is a source for op=0, op 0x04/0x05, op 0x28-0x2B. rs is always a source.
REQ-015 Memory op: op 0x20-0x2B.
REQ-016 Pair conflict SHALL be either of: dest(I1) equals a source of I2, or both slots are memory ops.
REQ-017 Load-use SHALL be: V1_EX=1, Instr1_EX is a load (op 0x20-0x25), and its rt (nonzero) is a source of Instr1_IN or Instr2_IN.
REQ-018 FSM states: RUN, LU_STALL. Reset state SHALL be RUN.
REQ-019 RUN with load-use and no FLUSH: FREEZE=1, single_fetch=0, ID/EX loads a bubble (V1_EX=V2_EX=0), next state LU_STALL.
REQ-020 LU_STALL: FREEZE=0; the held pair is issued per REQ-021/022 without a load-use check; next state RUN.
REQ-021 Issue with no pair conflict: Instr1_EX/Instr2_EX <= inputs, V1_EX=V2_EX=1, single_fetch=0.
REQ-022 Issue with a pair conflict: V1_EX=1, V2_EX=0, Instr2_EX <= 0, single_fetch=1.
REQ-023 CIA_EX SHALL load CIA_IN on every non-FREEZE edge.
REQ-024 Latency: exactly one cycle from IF/ID to ID/EX.
REQ-025 FLUSH=1 SHALL have priority over everything else: V1_EX=V2_EX=0, FREEZE=0, single_fetch=0, next state RUN.
REQ-026 single_fetch and FREEZE SHALL never be 1 in the same cycle.
REQ-027 Instruction 0x00000000 SHALL have no dest and SHALL never cause a conflict.

Reset
REQ-028 RESET low SHALL asynchronously clear all of: Instr1_EX, Instr2_EX, CIA_EX, V1_EX, V2_EX.
REQ-029 RESET low SHALL set the FSM to RUN.
REQ-030 While RESET is low, FREEZE=0 and single_fetch=0.
REQ-031 Reset asserted during LU_STALL SHALL abandon the stall with no residue.

Configuration
REQ-032 Macro ID_ISSUE_STATS_EN defined: add outputs split_cnt[15:0] and stall_cnt[15:0].
REQ-033 split_cnt SHALL increment on each REQ-022 issue. stall_cnt SHALL increment on each RUN->LU_STALL transition. Both wrap 0xFFFF->0x0000 and reset to 0.
REQ-034 Macro undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-035 I1=0x00221820 (add r3,r1,r2), I2=0x00642820 (add r5,r3,r4) -> single_fetch=1; next edge V1_EX=1, V2_EX=0.
REQ-036 I1=0x00221820, I2=0x00C72020 (add r4,r6,r7) -> single_fetch=0; next edge V1_EX=V2_EX=1.
REQ-037 Instr1_EX=0x8C030000 (lw r3) with V1_EX=1, I1 sourcing r3 -> FREEZE=1 one cycle, bubble in EX, then the pair issues.
REQ-038 FLUSH=1 in the same cycle as a load-use hazard -> FREEZE=0, V1_EX=V2_EX=0, state RUN.
REQ-039 I1=0x8C030000, I2=0xAC040004 (both memory ops) -> split; with ID_ISSUE_STATS_EN, split_cnt steps 0->1 and wraps from 0xFFFF to 0.
REQ-040 RESET pulsed low mid-LU_STALL -> all outputs 0, state RUN, no stray FREEZE after release.
